ps2_rx_fifo: RTL and testbench

//  Next-generation PS/2 device-to-host receiver. Oversamples ps2clk/ps2data in the clk domain,

---
 rtl/ps2_rx_fifo_if.sv | 40 ++++
 rtl/ps2_rx_fifo.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo_if
//   Read port of the PS/2 receive FIFO.
//
//   Handshake: the producer (modport master) presents rd_data with rd_valid
//   high whenever the FIFO holds at least one byte. A byte is transferred on a
//   posedge of clk where rd_valid and rd_ready are both high; rd_valid never
//   depends on rd_ready, and rd_ready may be held high while rd_valid is low
//   (nothing is transferred then).
//
//   Signals
//     rd_data     8 bits            FIFO head byte (held while rd_valid==0)
//     rd_valid    1                 FIFO not empty
//     rd_ready    1                 consumer accepts rd_data
//     fifo_count  $clog2(DEPTH)+1   number of bytes held
// ---------------------------------------------------------------------------
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [CW-1:0] fifo_count;

    modport master (
        output rd_data,
        output rd_valid,
        output fifo_count,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  fifo_count,
        output rd_ready
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//   PS/2 device-to-host receiver. Oversamples ps2clk/ps2data in the clk
//   domain, deglitches ps2clk, decodes 11-bit frames (start, 8 data bits
//   LSB-first, odd parity, stop), checks parity / stop / bit timeout and
//   buffers good bytes in a FIFO read through a valid/ready port.
//
//   Ports
//     clk           system clock, all logic on posedge
//     reset         synchronous, active-low reset
//     ps2clk        PS/2 clock line, open-drain (only ever driven low)
//     ps2data       PS/2 data line, never driven
//     en            receive enable; low forces the decoder idle
//     rd            read port (ps2_rx_fifo_if.master)
//     err_parity    1-cycle pulse: parity failed, frame dropped
//     err_frame     1-cycle pulse: stop bit was 0, frame dropped
//     err_timeout   1-cycle pulse: gap between clock falls too long
//     err_overflow  1-cycle pulse: good byte dropped, FIFO full
//     state_dbg     decoder state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
//   Build option
//     PS2_INHIBIT_EN  when defined, ps2clk is pulled low (host inhibit) while
//                     the FIFO is full and the decoder is idle.
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire               ps2clk,
    inout  wire               ps2data,
    input  logic              en,
    ps2_rx_fifo_if.master     rd,
    output logic              err_parity,
    output logic              err_frame,
    output logic              err_timeout,
    output logic              err_overflow,
    output logic [1:0]        state_dbg
);

    localparam int TO_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC) + 1;
    localparam int FW     = $clog2(FILTER_LEN);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers (idle level of both lines is high)
    // -----------------------------------------------------------------------
    logic clk_s1, clk_s2;
    logic dat_s1, dat_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2data;
            dat_s2 <= dat_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Clock deglitch filter. filt_cnt_q counts consecutive synced samples that
    // differ from the accepted level; the FILTER_LEN-th such sample flips it.
    // -----------------------------------------------------------------------
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (clk_s2 != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2;
                fall   = filt_q;     // accepted 1->0 transition
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Decoder FSM state
    // -----------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;

    // -----------------------------------------------------------------------
    // Bit timeout counter: cleared on every fall and while idle, saturates at
    // TO_CYC-1 so it can never wrap back into the legal range.
    // -----------------------------------------------------------------------
    logic [TW-1:0] to_cnt_q;
    logic          to_hit;

    assign to_hit = (to_cnt_q == TW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset || fall || state_q == IDLE) begin
            to_cnt_q <= '0;
        end else if (!to_hit) begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state / outputs
    // -----------------------------------------------------------------------
    logic push_req;
    logic perr_d, ferr_d, terr_d, oerr_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push_req  = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        terr_d    = 1'b0;

        if (!en) begin
            // Disabled: drop any partial frame without reporting it.
            state_d = IDLE;
        end else if (state_q != IDLE && !fall && to_hit) begin
            terr_d  = 1'b1;
            state_d = IDLE;
            shift_d = '0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                    shift_d = {dat_s2, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2;
                    state_d = STOP;
                end
                STOP: begin
                    if (!dat_s2) begin
                        ferr_d = 1'b1;
                    end else if (^{shift_q, par_q} == 1'b0) begin
                        perr_d = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    assign state_dbg = state_q;

    // -----------------------------------------------------------------------
    // Receive FIFO
    // -----------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
    logic [CW-1:0] count_q;
    logic [7:0]    rd_data_q;
    logic          full, pop, do_push;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign pop       = (count_q != '0) && rd.rd_ready;
    // A full FIFO still accepts a byte when a pop frees a slot the same cycle.
    assign do_push   = push_req && (!full || pop);
    assign oerr_d    = push_req && full && !pop;
    assign rd_ptr_nx = rd_ptr_q + AW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= shift_q;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nx;
            end
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // rd_data is a registered copy of the head. The new head is the
            // incoming byte when the FIFO is (or is becoming) empty; otherwise
            // the entry after the popped one. Otherwise it holds.
            if (do_push && (count_q == '0 || (pop && count_q == CW'(1)))) begin
                rd_data_q <= shift_q;
            end else if (pop && count_q > CW'(1)) begin
                rd_data_q <= mem[rd_ptr_nx];
            end
        end
    end

    assign rd.rd_data    = rd_data_q;
    assign rd.rd_valid   = (count_q != '0);
    assign rd.fifo_count = count_q;

    // -----------------------------------------------------------------------
    // Error pulses (at most one source is active in any cycle)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_parity   <= perr_d;
            err_frame    <= ferr_d;
            err_timeout  <= terr_d;
            err_overflow <= oerr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Line drivers
    // -----------------------------------------------------------------------
`ifdef PS2_INHIBIT_EN
    // Hold the device off while there is nowhere to put its next byte; only
    // between frames so a frame in flight is never cut short.
    assign ps2clk = (full && state_q == IDLE) ? 1'b0 : 1'bz;
`else
    assign ps2clk = 1'bz;
`endif
    assign ps2data = 1'bz;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int CLK_FREQ_HZ = 1_000_000;
  localparam int TIMEOUT_US  = 200;
  localparam int FILTER_LEN  = 4;
  localparam int FIFO_DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;
  always #5 clk = ~clk;

  // open-drain lines with pull-ups; device side drives only low
  wire  ps2clk;
  wire  ps2data;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  assign ps2clk  = dev_clk ? 1'bz : 1'b0;
  assign ps2data = dev_dat ? 1'bz : 1'b0;
  pullup (ps2clk);
  pullup (ps2data);

  logic       err_parity, err_frame, err_timeout, err_overflow;
  logic [1:0] state_dbg;

  ps2_rx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) rd_if ();

  ps2_rx_fifo #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2clk      (ps2clk),
    .ps2data     (ps2data),
    .en          (en),
    .rd          (rd_if),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_timeout (err_timeout),
    .err_overflow(err_overflow),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0, n_multi = 0;
  int b_par, b_frm, b_to, b_ovf;

  always @(negedge clk) begin
    if (err_parity)   n_par++;
    if (err_frame)    n_frm++;
    if (err_timeout)  n_to++;
    if (err_overflow) n_ovf++;
    if (32'(err_parity) + 32'(err_frame) + 32'(err_timeout) + 32'(err_overflow) > 1) n_multi++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic snap();
    b_par = n_par; b_frm = n_frm; b_to = n_to; b_ovf = n_ovf;
  endtask

  task automatic check_errs(input string nm, input int ep, input int ef, input int et, input int eo);
    check({nm, " err_parity"},   32'(n_par - b_par), 32'(ep));
    check({nm, " err_frame"},    32'(n_frm - b_frm), 32'(ef));
    check({nm, " err_timeout"},  32'(n_to - b_to),   32'(et));
    check({nm, " err_overflow"}, 32'(n_ovf - b_ovf), 32'(eo));
  endtask

  // ---------------- driver tasks ----------------
  // 80-cycle PS/2 period: data changes mid-high, then 40 cycles low.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] fr;
    fr = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      repeat (20) @(negedge clk);
      dev_dat = fr[i];
      repeat (20) @(negedge clk);
      dev_clk = 1'b0;
      repeat (40) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (20) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, 11);
  endtask

  task automatic pop_check(input string nm);
    int w;
    logic [7:0] e;
    w = 0;
    while (!rd_if.rd_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({nm, " rd_valid"}, 32'(rd_if.rd_valid), 32'd1);
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: got 0x%0h expected no data", nm, rd_if.rd_data);
    end else begin
      e = exp_q.pop_front();
      check({nm, " rd_data"}, 32'(rd_if.rd_data), 32'(e));
    end
    rd_if.rd_ready = 1'b1;
    @(negedge clk);
    rd_if.rd_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] b;
    logic       par_ok;
    logic       stp;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int w;
    logic push;

    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    rd_if.rd_ready = 1'b0;

    // reset state
    repeat (4) @(negedge clk);
    check("reset fifo_count", 32'(rd_if.fifo_count), 0);
    check("reset rd_valid",   32'(rd_if.rd_valid), 0);
    check("reset rd_data",    32'(rd_if.rd_data), 0);
    check("reset state",      32'(state_dbg), 0);
    check("reset errs",       32'({err_parity, err_frame, err_timeout, err_overflow}), 0);
    check("reset ps2clk",     32'(ps2clk), 1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // table: single frames, good and bad
    for (int i = 0; i < 7; i++) begin
      push = !vecs[i].exp_perr && !vecs[i].exp_ferr;
      snap();
      send_frame(vecs[i].b, vecs[i].par_ok ? ~^vecs[i].b : ^vecs[i].b, vecs[i].stp, 11);
      repeat (5) @(negedge clk);
      check_errs($sformatf("vec%0d", i), 32'(vecs[i].exp_perr), 32'(vecs[i].exp_ferr), 0, 0);
      check($sformatf("vec%0d fifo_count", i), 32'(rd_if.fifo_count), push ? 1 : 0);
      if (push) begin
        exp_q.push_back(vecs[i].b);
        pop_check($sformatf("vec%0d pop", i));
        @(negedge clk);
        check($sformatf("vec%0d rd_valid after pop", i), 32'(rd_if.rd_valid), 0);
      end
    end

    // timeout on a partial frame, then recovery
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 4);
    check("timeout state DATA", 32'(state_dbg), 1);
    w = 0;
    while (!err_timeout && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("timeout latency window", 32'(w >= 130 && w <= 160), 1);
    @(negedge clk);
    check("timeout state IDLE", 32'(state_dbg), 0);
    check_errs("timeout", 0, 0, 1, 0);
    snap();
    send_good(8'h5A);
    exp_q.push_back(8'h5A);
    repeat (5) @(negedge clk);
    check_errs("after timeout", 0, 0, 0, 0);
    pop_check("after timeout pop");

    // fill the FIFO with rd_ready low
    snap();
    for (int k = 1; k <= 4; k++) begin
      send_good(8'(k));
      exp_q.push_back(8'(k));
    end
    repeat (5) @(negedge clk);
    check("full fifo_count", 32'(rd_if.fifo_count), 4);
`ifdef PS2_INHIBIT_EN
    check("inhibit ps2clk low", 32'(ps2clk), 0);
    pop_check("inhibit pop1");
    repeat (2) @(negedge clk);
    check("inhibit released", 32'(ps2clk), 1);
    check_errs("inhibit", 0, 0, 0, 0);
    for (int k = 2; k <= 4; k++) pop_check($sformatf("drain pop%0d", k));
`else
    send_good(8'h05);
    repeat (5) @(negedge clk);
    check_errs("overflow", 0, 0, 0, 1);
    check("overflow fifo_count", 32'(rd_if.fifo_count), 4);
    for (int k = 1; k <= 4; k++) pop_check($sformatf("drain pop%0d", k));
`endif
    @(negedge clk);
    check("drained rd_valid", 32'(rd_if.rd_valid), 0);
    check("drained rd_data held", 32'(rd_if.rd_data), 32'h04);

    // short low glitches on ps2clk with data low
    snap();
    dev_dat = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (2) @(negedge clk);
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk = 1'b0;
    repeat (3) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch state IDLE", 32'(state_dbg), 0);
    dev_dat = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch fifo_count", 32'(rd_if.fifo_count), 0);
    check_errs("glitch", 0, 0, 0, 0);

    // reset mid-frame clears a partial frame and the FIFO
    snap();
    send_good(8'h11);
    send_frame(8'hAA, 1'b1, 1'b1, 6);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset fifo_count", 32'(rd_if.fifo_count), 0);
    check("midreset rd_data", 32'(rd_if.rd_data), 0);
    check("midreset state", 32'(state_dbg), 0);
    send_good(8'h33);
    exp_q.push_back(8'h33);
    repeat (5) @(negedge clk);
    check("midreset next fifo_count", 32'(rd_if.fifo_count), 1);
    check_errs("midreset", 0, 0, 0, 0);
    pop_check("midreset pop");

    // en low mid-frame drops the partial frame silently
    snap();
    send_frame(8'h44, 1'b1, 1'b1, 5);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("en low state", 32'(state_dbg), 0);
    en = 1'b1;
    send_good(8'h44);
    exp_q.push_back(8'h44);
    repeat (300) @(negedge clk);
    check("en fifo_count", 32'(rd_if.fifo_count), 1);
    check_errs("en", 0, 0, 0, 0);
    pop_check("en pop");

    check("error pulses exclusive", 32'(n_multi), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
